// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, rounding/saturation mode constants and the
// realign/round/saturate helper used by the FFT butterfly datapath.
//   DW_DEF / TW_DEF / FRAC_DEF : default data, twiddle and fraction widths
//   RND_* / SAT_*              : values for the RND and SAT parameters
//   sat_trunc()                : arithmetic shift with optional round-half-up,
//                                wrap or clamp to dw bits, plus overflow bit
package fft_pkg;

    localparam int DW_DEF   = 32;
    localparam int TW_DEF   = 32;
    localparam int FRAC_DEF = 16;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;
    localparam int SAT_WRAP    = 0;
    localparam int SAT_CLAMP   = 1;

    // Working widths of the helper; callers sign-extend into PMAX bits and
    // take the low dw bits of the result. Requires DW+TW+2 < PMAX, dw <= RMAX.
    localparam int PMAX = 128;
    localparam int RMAX = 64;

    typedef struct packed {
        logic [RMAX-1:0] res;
        logic            ovf;
    } sat_res_t;

    function automatic sat_res_t sat_trunc(
        input logic signed [PMAX-1:0] value,
        input int unsigned            s,
        input bit                     rnd,
        input bit                     sat,
        input int unsigned            dw
    );
        logic signed [PMAX-1:0] v;
        logic signed [PMAX-1:0] one;
        logic signed [PMAX-1:0] sh;
        logic signed [PMAX-1:0] lim_hi;
        logic signed [PMAX-1:0] lim_lo;
        sat_res_t               r;
        one    = '0;
        one[0] = 1'b1;
        v      = value;
        // Half-LSB bias before the floor shift: ties go toward +infinity.
        if (rnd && (s != 0)) begin
            v = v + (one <<< (s - 1));
        end
        sh     = v >>> s;
        lim_hi = (one <<< (dw - 1)) - one;
        lim_lo = -(one <<< (dw - 1));
        r.ovf  = (sh > lim_hi) || (sh < lim_lo);
        if (sat && r.ovf) begin
            r.res = sh[PMAX-1] ? lim_lo[RMAX-1:0] : lim_hi[RMAX-1:0];
        end else begin
            r.res = sh[RMAX-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/cmul_pipe.sv
// cmul_pipe: registered partial products of the complex multiply y*w.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_en        : load enable (pipeline advance with a valid operand)
//   i_yr, i_yi  : operand y (DW bits, signed)
//   i_wr, i_wi  : twiddle w (TW bits, signed)
//   o_p_rr      : yr*wr      o_p_ii : yi*wi
//   o_p_ri      : yr*wi      o_p_ir : yi*wr   (DW+TW bits each, signed)
module cmul_pipe
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic signed [DW-1:0]    i_yr,
    input  logic signed [DW-1:0]    i_yi,
    input  logic signed [TW-1:0]    i_wr,
    input  logic signed [TW-1:0]    i_wi,
    output logic signed [DW+TW-1:0] o_p_rr,
    output logic signed [DW+TW-1:0] o_p_ii,
    output logic signed [DW+TW-1:0] o_p_ri,
    output logic signed [DW+TW-1:0] o_p_ir
);

    localparam int PW = DW + TW;

    logic signed [PW-1:0] r_p_rr;
    logic signed [PW-1:0] r_p_ii;
    logic signed [PW-1:0] r_p_ri;
    logic signed [PW-1:0] r_p_ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
        end else if (i_en) begin
            r_p_rr <= PW'(i_yr) * PW'(i_wr);
            r_p_ii <= PW'(i_yi) * PW'(i_wi);
            r_p_ri <= PW'(i_yr) * PW'(i_wi);
            r_p_ir <= PW'(i_yi) * PW'(i_wr);
        end
    end

    assign o_p_rr = r_p_rr;
    assign o_p_ii = r_p_ii;
    assign o_p_ri = r_p_ri;
    assign o_p_ir = r_p_ir;

endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage pipelined radix-2 DIT butterfly,
//   a = x + y*w, b = x - y*w, signed fixed point, valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready = global advance enable)
//   xr, xi, yr, yi       : complex operands x, y (DW bits)
//   wr, wi               : complex twiddle w (TW bits, FRAC fractional bits)
//   scale                : 1 = extra divide-by-2 on this transaction
//   tag_in / tag_out     : opaque tag carried with the transaction
//   out_valid / out_ready: output handshake
//   ar, ai, br, bi       : results a, b (DW bits)
//   ovf / ovf_clr        : sticky overflow flag and its synchronous clear
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TW   = TW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int RND  = RND_TRUNC,
    parameter int SAT  = SAT_WRAP,
    parameter int TAGW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] xr,
    input  logic signed [DW-1:0] xi,
    input  logic signed [DW-1:0] yr,
    input  logic signed [DW-1:0] yi,
    input  logic signed [TW-1:0] wr,
    input  logic signed [TW-1:0] wi,
    input  logic                 scale,
    input  logic [TAGW-1:0]      tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        ar,
    output logic [DW-1:0]        ai,
    output logic [DW-1:0]        br,
    output logic [DW-1:0]        bi,
    output logic [TAGW-1:0]      tag_out,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam int P      = DW + TW + 2;
    localparam int PW     = DW + TW;
    localparam bit RND_ON = (RND == RND_HALF_UP);
    localparam bit SAT_ON = (SAT == SAT_CLAMP);

    // Single advance enable: every stage moves together, bubbles included.
    logic w_en;
    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    // ---------------- S1: operands, scale, tag ----------------
    logic                 r_s1_valid;
    logic signed [DW-1:0] r_s1_xr;
    logic signed [DW-1:0] r_s1_xi;
    logic signed [DW-1:0] r_s1_yr;
    logic signed [DW-1:0] r_s1_yi;
    logic signed [TW-1:0] r_s1_wr;
    logic signed [TW-1:0] r_s1_wi;
    logic                 r_s1_scale;
    logic [TAGW-1:0]      r_s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_xr    <= '0;
            r_s1_xi    <= '0;
            r_s1_yr    <= '0;
            r_s1_yi    <= '0;
            r_s1_wr    <= '0;
            r_s1_wi    <= '0;
            r_s1_scale <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_xr    <= xr;
                r_s1_xi    <= xi;
                r_s1_yr    <= yr;
                r_s1_yi    <= yi;
                r_s1_wr    <= wr;
                r_s1_wi    <= wi;
                r_s1_scale <= scale;
                r_s1_tag   <= tag_in;
            end
        end
    end

    // ---------------- S2: products, with x/scale/tag alongside ----------------
    logic                 r_s2_valid;
    logic signed [DW-1:0] r_s2_xr;
    logic signed [DW-1:0] r_s2_xi;
    logic                 r_s2_scale;
    logic [TAGW-1:0]      r_s2_tag;
    logic signed [PW-1:0] w_p_rr;
    logic signed [PW-1:0] w_p_ii;
    logic signed [PW-1:0] w_p_ri;
    logic signed [PW-1:0] w_p_ir;

    cmul_pipe #(
        .DW(DW),
        .TW(TW)
    ) u_cmul (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_en & r_s1_valid),
        .i_yr   (r_s1_yr),
        .i_yi   (r_s1_yi),
        .i_wr   (r_s1_wr),
        .i_wi   (r_s1_wi),
        .o_p_rr (w_p_rr),
        .o_p_ii (w_p_ii),
        .o_p_ri (w_p_ri),
        .o_p_ir (w_p_ir)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_xr    <= '0;
            r_s2_xi    <= '0;
            r_s2_scale <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_xr    <= r_s1_xr;
                r_s2_xi    <= r_s1_xi;
                r_s2_scale <= r_s1_scale;
                r_s2_tag   <= r_s1_tag;
            end
        end
    end

    // ---------------- S3 combinational: align, sum, round, saturate ----------------
    logic signed [P-1:0] w_xr_al;
    logic signed [P-1:0] w_xi_al;
    logic signed [P-1:0] w_e_rr;
    logic signed [P-1:0] w_e_ii;
    logic signed [P-1:0] w_e_ri;
    logic signed [P-1:0] w_e_ir;
    logic signed [P-1:0] w_pr;
    logic signed [P-1:0] w_pi;
    logic signed [P-1:0] w_qr;
    logic signed [P-1:0] w_qi;
    int unsigned         w_shift;
    sat_res_t            w_sr_ar;
    sat_res_t            w_sr_ai;
    sat_res_t            w_sr_br;
    sat_res_t            w_sr_bi;
    logic                w_any_ovf;

    // x is brought onto the product's binary point before the sums.
    assign w_xr_al = P'(r_s2_xr) <<< FRAC;
    assign w_xi_al = P'(r_s2_xi) <<< FRAC;
    assign w_e_rr  = P'(w_p_rr);
    assign w_e_ii  = P'(w_p_ii);
    assign w_e_ri  = P'(w_p_ri);
    assign w_e_ir  = P'(w_p_ir);

    assign w_pr = w_xr_al + w_e_rr - w_e_ii;
    assign w_pi = w_xi_al + w_e_ri + w_e_ir;
    assign w_qr = w_xr_al - w_e_rr + w_e_ii;
    assign w_qi = w_xi_al - w_e_ri - w_e_ir;

    always_comb begin
        w_shift   = FRAC + (r_s2_scale ? 1 : 0);
        w_sr_ar   = sat_trunc(PMAX'(w_pr), w_shift, RND_ON, SAT_ON, DW);
        w_sr_ai   = sat_trunc(PMAX'(w_pi), w_shift, RND_ON, SAT_ON, DW);
        w_sr_br   = sat_trunc(PMAX'(w_qr), w_shift, RND_ON, SAT_ON, DW);
        w_sr_bi   = sat_trunc(PMAX'(w_qi), w_shift, RND_ON, SAT_ON, DW);
        w_any_ovf = w_sr_ar.ovf | w_sr_ai.ovf | w_sr_br.ovf | w_sr_bi.ovf;
    end

    // ---------------- S3 registers: results, tag, valid ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ar        <= '0;
            ai        <= '0;
            br        <= '0;
            bi        <= '0;
            tag_out   <= '0;
        end else if (w_en) begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                ar      <= w_sr_ar.res[DW-1:0];
                ai      <= w_sr_ai.res[DW-1:0];
                br      <= w_sr_br.res[DW-1:0];
                bi      <= w_sr_bi.res[DW-1:0];
                tag_out <= r_s2_tag;
            end
        end
    end

    // Overflow is sampled only when a new result is loaded, so a held
    // result cannot re-raise the flag after a clear. Set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | (w_en & r_s2_valid & w_any_ovf);
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
module tb_butterfly_pipe;

    localparam int DW   = 32;
    localparam int TW   = 32;
    localparam int FRAC = 16;
    localparam int TAGW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic [DW-1:0]   xr = '0, xi = '0, yr = '0, yi = '0;
    logic [TW-1:0]   wr = '0, wi = '0;
    logic            scale = 1'b0;
    logic [TAGW-1:0] tag_in = '0;
    logic            out_ready = 1'b1;
    logic            ovf_clr = 1'b0;

    logic            in_ready0, out_valid0, ovf0;
    logic [DW-1:0]   ar0, ai0, br0, bi0;
    logic [TAGW-1:0] tag_out0;
    logic            in_ready1, out_valid1, ovf1;
    logic [DW-1:0]   ar1, ai1, br1, bi1;
    logic [TAGW-1:0] tag_out1;

    // dut0: truncate + wrap (legacy-exact), dut1: round-half-up + saturate
    butterfly_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC), .RND(0), .SAT(0), .TAGW(TAGW)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .xr(xr), .xi(xi), .yr(yr), .yi(yi), .wr(wr), .wi(wi), .scale(scale),
        .tag_in(tag_in), .out_valid(out_valid0), .out_ready(out_ready),
        .ar(ar0), .ai(ai0), .br(br0), .bi(bi0), .tag_out(tag_out0),
        .ovf(ovf0), .ovf_clr(ovf_clr));

    butterfly_pipe #(.DW(DW), .TW(TW), .FRAC(FRAC), .RND(1), .SAT(1), .TAGW(TAGW)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .xr(xr), .xi(xi), .yr(yr), .yi(yi), .wr(wr), .wi(wi), .scale(scale),
        .tag_in(tag_in), .out_valid(out_valid1), .out_ready(out_ready),
        .ar(ar1), .ai(ai1), .br(br1), .bi(bi1), .tag_out(tag_out1),
        .ovf(ovf1), .ovf_clr(ovf_clr));

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [31:0]     ar0, ai0, br0, bi0;
        logic [31:0]     ar1, ai1, br1, bi1;
        bit              ov0, ov1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_ovf_en = 1'b1;
    bit   st0 = 1'b0, st1 = 1'b0;
    bit   rnd_bp = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Exact rational reference: floor(num / 2^s) (optionally of num + 2^(s-1)),
    // then wrap or clamp into 32 signed bits.
    function automatic void quant(input logic signed [127:0] num, input int s, input bit rnd,
                                  input bit sat, output logic [31:0] res, output bit ov);
        logic signed [127:0] div, n, q, lim_hi, lim_lo;
        div = 128'sd1;
        for (int i = 0; i < s; i++) div = div * 2;
        n = num;
        if (rnd) n = n + div / 2;
        q = n / div;
        if ((n % div != 0) && (n < 0)) q = q - 1;
        lim_hi = 128'sd2147483647;
        lim_lo = -128'sd2147483648;
        ov = (q > lim_hi) || (q < lim_lo);
        if (sat && ov) res = (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else           res = q[31:0];
    endfunction

    function automatic exp_t model(input logic signed [31:0] mxr, mxi, myr, myi, mwr, mwi,
                                   input bit sc, input logic [TAGW-1:0] tg);
        logic signed [127:0] XR, XI, YR, YI, WR, WI, mr, mi, a_r, a_i, b_r, b_i;
        exp_t e;
        bit o1, o2, o3, o4;
        int s;
        XR = mxr; XI = mxi; YR = myr; YI = myi; WR = mwr; WI = mwi;
        mr  = YR * WR - YI * WI;
        mi  = YR * WI + YI * WR;
        a_r = XR * 65536 + mr;  a_i = XI * 65536 + mi;
        b_r = XR * 65536 - mr;  b_i = XI * 65536 - mi;
        s = FRAC + (sc ? 1 : 0);
        e.tag = tg;
        quant(a_r, s, 1'b0, 1'b0, e.ar0, o1);
        quant(a_i, s, 1'b0, 1'b0, e.ai0, o2);
        quant(b_r, s, 1'b0, 1'b0, e.br0, o3);
        quant(b_i, s, 1'b0, 1'b0, e.bi0, o4);
        e.ov0 = o1 | o2 | o3 | o4;
        quant(a_r, s, 1'b1, 1'b1, e.ar1, o1);
        quant(a_i, s, 1'b1, 1'b1, e.ai1, o2);
        quant(b_r, s, 1'b1, 1'b1, e.br1, o3);
        quant(b_i, s, 1'b1, 1'b1, e.bi1, o4);
        e.ov1 = o1 | o2 | o3 | o4;
        return e;
    endfunction

    // Drive one transaction from a falling edge; returns 1 time unit after
    // the rising edge that accepted it.
    task automatic send(input logic [31:0] a_xr, a_xi, a_yr, a_yi, a_wr, a_wi,
                        input bit sc, input logic [TAGW-1:0] tg);
        bit acc;
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        xr = a_xr; xi = a_xi; yr = a_yr; yi = a_yi; wr = a_wr; wi = a_wi;
        scale = sc; tag_in = tg;
        acc = 1'b0;
        guard = 0;
        while (!acc) begin
            #4;
            acc = in_ready0;
            if (acc) sb.push_back(model(a_xr, a_xi, a_yr, a_yi, a_wr, a_wi, sc, tg));
            @(posedge clk);
            if (!acc) begin
                guard++;
                if (guard > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: tag %0h not accepted, expected acceptance", tg);
                    in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #1;
        chk("ovf_clr_wrap", ovf0, 0);
        chk("ovf_clr_sat", ovf1, 0);
        st0 = 1'b0;
        st1 = 1'b0;
    endtask

    // Latency and directed values: out_valid rises exactly on the third edge.
    task automatic lat_test(input string nm, input logic [31:0] a_xr, a_xi, a_yr, a_yi, a_wr, a_wi,
                            input bit sc, input logic [TAGW-1:0] tg,
                            input logic [31:0] e_ar0, e_ai0, e_br0, e_bi0, e_ar1, e_br1);
        send(a_xr, a_xi, a_yr, a_yi, a_wr, a_wi, sc, tg);
        chk({nm, "_lat1"}, out_valid0, 0);
        @(posedge clk); #1;
        chk({nm, "_lat2"}, out_valid0, 0);
        @(posedge clk); #1;
        chk({nm, "_lat3"}, out_valid0, 1);
        chk({nm, "_ar0"}, ar0, e_ar0);
        chk({nm, "_ai0"}, ai0, e_ai0);
        chk({nm, "_br0"}, br0, e_br0);
        chk({nm, "_bi0"}, bi0, e_bi0);
        chk({nm, "_ar1"}, ar1, e_ar1);
        chk({nm, "_br1"}, br1, e_br1);
        drain();
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_valid0 && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: tag %0h presented, expected no output", tag_out0);
                end else begin
                    e = sb.pop_front();
                    chk("tag0", tag_out0, e.tag);
                    chk("tag1", tag_out1, e.tag);
                    chk("valid1", out_valid1, 1);
                    chk("ar_wrap", ar0, e.ar0);
                    chk("ai_wrap", ai0, e.ai0);
                    chk("br_wrap", br0, e.br0);
                    chk("bi_wrap", bi0, e.bi0);
                    chk("ar_sat", ar1, e.ar1);
                    chk("ai_sat", ai1, e.ai1);
                    chk("br_sat", br1, e.br1);
                    chk("bi_sat", bi1, e.bi1);
                    st0 = st0 | e.ov0;
                    st1 = st1 | e.ov1;
                    if (mon_ovf_en) begin
                        chk("ovf_wrap", ovf0, st0);
                        chk("ovf_sat", ovf1, st1);
                    end
                end
            end
        end
    end

    // Random backpressure during the random phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [31:0] rv();
        logic [31:0] v;
        v = $urandom();
        if ($urandom_range(0, 1) == 1) v = {{12{v[19]}}, v[19:0]};
        return v;
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_ar", ar0, 0);
        chk("rst_tag", tag_out0, 0);
        chk("rst_ovf", ovf0, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready0", in_ready0, 1);
        chk("rst_in_ready1", in_ready1, 1);

        // Directed cases
        lat_test("basic", 32'h0001_0000, 0, 32'h0000_8000, 0, 32'h0001_0000, 0, 1'b0, 8'h10,
                 32'h0001_8000, 0, 32'h0000_8000, 0, 32'h0001_8000, 32'h0000_8000);
        lat_test("twj", 32'h0001_0000, 0, 32'h0001_0000, 0, 0, 32'h0001_0000, 1'b0, 8'h11,
                 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000,
                 32'h0001_0000, 32'h0001_0000);
        lat_test("rnd", 0, 0, 32'h0000_0001, 0, 32'h0000_8000, 0, 1'b0, 8'h12,
                 0, 0, 32'hFFFF_FFFF, 0, 32'h0000_0001, 0);
        lat_test("ovf", 32'h7FFF_0000, 0, 32'h7FFF_0000, 0, 32'h0001_0000, 0, 1'b0, 8'h13,
                 32'hFFFE_0000, 0, 0, 0, 32'h7FFF_FFFF, 0);
        chk("ovf_set_wrap", ovf0, 1);
        chk("ovf_set_sat", ovf1, 1);
        clear_ovf();
        lat_test("scl", 32'h7FFF_0000, 0, 32'h7FFF_0000, 0, 32'h0001_0000, 0, 1'b1, 8'h14,
                 32'h7FFF_0000, 0, 0, 0, 32'h7FFF_0000, 0);
        chk("scl_no_ovf_wrap", ovf0, 0);
        chk("scl_no_ovf_sat", ovf1, 0);

        // Backpressure: 6 back-to-back, out_ready low for cycles 4..8;
        // tag 1 overflows and is cleared while held.
        mon_ovf_en = 1'b0;
        fork
            begin
                send(32'h7FFF_0000, 0, 32'h7FFF_0000, 0, 32'h0001_0000, 0, 1'b0, 8'd1);
                for (int t = 2; t <= 6; t++)
                    send(32'(t) << 16, 32'h0000_1000, 32'(t) << 12, 32'hFFFF_F000,
                         32'h0000_B505, 32'hFFFF_4AFB, t[0], 8'(t));
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (2) @(negedge clk);
                ovf_clr = 1'b1;
                #4;
                chk("bp_in_ready0", in_ready0, 0);
                chk("bp_in_ready1", in_ready1, 0);
                chk("bp_out_valid", out_valid0, 1);
                @(negedge clk);
                ovf_clr = 1'b0;
                @(negedge clk);
                #1;
                chk("bp_held_ovf_wrap", ovf0, 0);
                chk("bp_held_ovf_sat", ovf1, 0);
                @(negedge clk);
                out_ready = 1'b1;
                #4;
                chk("bp_release_ready", in_ready0, 1);
            end
        join
        drain();
        chk("bp_ovf_after_wrap", ovf0, 0);
        chk("bp_ovf_after_sat", ovf1, 0);
        st0 = 1'b0;
        st1 = 1'b0;
        mon_ovf_en = 1'b1;

        // Reset with three transactions in flight
        for (int t = 0; t < 3; t++)
            send(32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 0, 32'h0001_0000, 0, 1'b0, 8'(8'h20 + t));
        rst_n = 1'b0;
        sb.delete();
        st0 = 1'b0;
        st1 = 1'b0;
        #1;
        chk("mrst_out_valid0", out_valid0, 0);
        chk("mrst_out_valid1", out_valid1, 0);
        chk("mrst_ar", ar0, 0);
        chk("mrst_bi", bi1, 0);
        chk("mrst_tag", tag_out0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lat_test("post_rst", 32'h0001_0000, 0, 32'h0000_8000, 0, 32'h0001_0000, 0, 1'b0, 8'h30,
                 32'h0001_8000, 0, 32'h0000_8000, 0, 32'h0001_8000, 32'h0000_8000);

        // Random traffic with random backpressure and bubbles
        rnd_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(rv(), rv(), rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)), 8'(n));
        end
        rnd_bp = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath. Computes a = x + y·w and b = x − y·w on signed fixed-point complex operands.
- Adds a valid/ready handshake, a per-transaction ÷2 scaling flag, selectable rounding and saturation, a sticky overflow flag and a passthrough tag.
- Sits between the stage memory read port and the write-back port of each FFT stage.
- With defaults and RND=0, SAT=0, scale=0 it is bit-exact with the existing combinational butterfly: Q16 data, Q16 twiddles, truncation, wrap.

Parameters:
- DW, 32, data width (x, y, a, b), signed two's complement
- TW, 32, twiddle width (wr, wi), signed
- FRAC, 16, twiddle fractional bits; product realignment shift
- RND, 0, 0 = truncate (floor); 1 = round-half-up before the shift
- SAT, 0, 0 = wrap to DW bits; 1 = saturate to the DW-bit signed range
- TAGW, 8, width of the opaque tag carried alongside the data

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- xr, xi, yr, yi  in  DW each  complex operands x, y
- wr, wi  in  TW each  complex twiddle w
- scale  in  1  1 = results divided by 2 (extra arithmetic right shift)
- tag_in  in  TAGW  opaque tag, returned with the results
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- ar, ai, br, bi  out  DW each  results a, b
- tag_out  out  TAGW  tag of the current result
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset: all stage valid bits 0; out_valid=0; ar/ai/br/bi/tag_out=0; ovf=0. in_ready=1 once rst_n is high. Reset asserted mid-operation discards every in-flight transaction; no partial outputs.
- Pipeline: 3 register stages, so latency is exactly 3 cycles from input acceptance to out_valid under no stall.
  - S1 registers the operands, scale and tag.
  - S2 registers the four products yr·wr, yi·wi, yr·wi, yi·wr (DW+TW bits each).
  - S3 registers the final a and b.
- Flow control: a single global advance enable, en = ~out_valid | out_ready.
  - in_ready = en (combinational from out_ready; the path is accepted).
  - A transfer happens when in_valid & in_ready. All stages shift only when en=1.
  - Bubbles do not collapse.
  - While out_valid=1 and out_ready=0, all stage registers and outputs hold, and inputs are not accepted.
- Throughput: 1 transaction/cycle when out_ready is held high.
- Arithmetic (S3), internal width P = DW+TW+2:
  - pr = (xr<<<FRAC) + yr·wr − yi·wi; pi = (xi<<<FRAC) + yr·wi + yi·wr.
  - qr, qi are the same with the product terms negated.
  - Shift amount s = FRAC + scale.
  - RND=1: add 1<<(s−1) before the shift; ties round toward +∞.
  - Result = P-bit value >>> s (arithmetic).
- Overflow: the shifted result does not fit in DW signed bits.
  - SAT=1: clamp to 2^(DW−1)−1 or −2^(DW−1).
  - SAT=0: keep the low DW bits (wrap).
  - Detection is active in both modes. Any of the four outputs overflowing on an accepted S3 update sets ovf.
- ovf: sticky. ovf_clr clears it on the next edge; set wins over a simultaneous clear. A held (stalled) result is counted once only.
- tag and scale travel with their transaction through all stages.

Decomposition:
- Package fft_pkg holds:
  - default widths DW_DEF=32, TW_DEF=32, FRAC_DEF=16
  - rounding/saturation mode constants
  - a function sat_trunc(value, s, rnd, sat) returning the DW-bit result plus an overflow bit
- One natural sub-module: cmul_pipe, the registered complex multiplier producing the four products. butterfly_pipe instantiates it and owns the handshake, alignment, rounding, saturation and overflow logic.

Test Plan:
- Basic Q16: xr=0x00010000, xi=0, yr=0x00008000, yi=0, wr=0x00010000, wi=0 → after 3 cycles ar=0x00018000, br=0x00008000, ai=bi=0, ovf=0.
- Twiddle j: x=(0x00010000,0), y=(0x00010000,0), w=(0,0x00010000) → a=(0x00010000,0x00010000), b=(0x00010000,0xFFFF0000).
- Overflow: xr=yr=0x7FFF0000, w=1.0, scale=0:
  - SAT=0 → ar=0xFFFE0000, ovf=1.
  - SAT=1 → ar=0x7FFFFFFF, ovf=1.
  - Repeat with scale=1 → ar=0x7FFF0000, no new overflow.
  - Pulse ovf_clr → ovf=0.
- Rounding: yr=0x00000001, wr=0x00008000 (0.5), x=0:
  - RND=0 → ar=0.
  - RND=1 → ar=1, br=0 (−0.5 rounds up to 0).
- Backpressure: stream 6 back-to-back transactions with tags 1..6, out_ready low for cycles 4–8.
  - Outputs arrive in order 1..6 with no loss or duplication.
  - in_ready=0 exactly while out_valid & ~out_ready.
  - ovf is not re-counted on held results.
- Reset mid-stream: drop rst_n with 3 transactions in flight → out_valid=0 and outputs 0 immediately. After release, the first new input appears 3 cycles after acceptance.
